// File: rtl/ni_minbd.sv
// Node-side network interface for a minBD router: injection queue with grant/retry FSM, dual-write ejection FIFO.
// Optional statistics counters are built when NI_STATS_EN is defined; otherwise inj_cnt/ej_cnt/retry_cnt read 0.

`ifndef WIDTH_FLIT_EXT
`define WIDTH_FLIT_EXT 40
`endif
`ifndef FLIT_EXT_VLD_BIT
`define FLIT_EXT_VLD_BIT 39
`endif
`ifndef FLIT_EXT_GOLDEN_BIT
`define FLIT_EXT_GOLDEN_BIT 38
`endif

module ni_minbd #(
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 8,
    parameter int GNT_LAT   = 2,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inj_valid,
    output logic                          inj_ready,
    input  logic [`WIDTH_FLIT_EXT-1:0]    inj_flit,
    output logic [`WIDTH_FLIT_EXT-1:0]    din_l,
    input  logic                          local_inject_gnt,
    input  logic [`WIDTH_FLIT_EXT-1:0]    dout_l_1,
    input  logic [`WIDTH_FLIT_EXT-1:0]    dout_l_2,
    output logic                          ej_valid,
    input  logic                          ej_ready,
    output logic [`WIDTH_FLIT_EXT-1:0]    ej_flit,
    output logic                          ej_overflow,
    output logic [CNT_W-1:0]              inj_cnt,
    output logic [CNT_W-1:0]              ej_cnt,
    output logic [CNT_W-1:0]              retry_cnt,
    output logic [1:0]                    o_dbg_state,
    output logic [$clog2(INJ_DEPTH):0]    o_dbg_inj_count,
    output logic [$clog2(EJ_DEPTH):0]     o_dbg_ej_count
);

    localparam int FW    = `WIDTH_FLIT_EXT;
    localparam int VB    = `FLIT_EXT_VLD_BIT;
    localparam int GB    = `FLIT_EXT_GOLDEN_BIT;
    localparam int IAW   = $clog2(INJ_DEPTH);
    localparam int EAW   = $clog2(EJ_DEPTH);
    localparam int LAT_W = (GNT_LAT > 1) ? $clog2(GNT_LAT) : 1;

    localparam logic [IAW:0]       INJ_FULL = (IAW+1)'(INJ_DEPTH);
    localparam logic [EAW:0]       EJ_FULL  = (EAW+1)'(EJ_DEPTH);
    localparam logic [LAT_W-1:0]   LAT_INIT = LAT_W'(GNT_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESENT = 2'd1,
        S_WAIT    = 2'd2
    } state_t;

    // ---------------- injection FIFO ----------------
    logic [FW-1:0]    r_inj_mem [INJ_DEPTH];
    logic [IAW-1:0]   r_inj_wp;
    logic [IAW-1:0]   r_inj_rp;
    logic [IAW:0]     r_inj_count;
    logic             r_alive;
    logic [FW-1:0]    w_inj_wdata;
    logic [FW-1:0]    w_inj_head;
    logic             w_inj_push;
    logic             w_inj_pop;
    logic             w_retry;

    // Core-side vld/golden are meaningless here; store them cleared so the held payload is clean.
    always_comb begin
        w_inj_wdata     = inj_flit;
        w_inj_wdata[VB] = 1'b0;
        w_inj_wdata[GB] = 1'b0;
    end

    assign w_inj_head = r_inj_mem[r_inj_rp];
    assign inj_ready  = r_alive && (r_inj_count != INJ_FULL);
    assign w_inj_push = inj_valid && inj_ready;

    always_ff @(posedge clk) begin
        if (w_inj_push) begin
            r_inj_mem[r_inj_wp] <= w_inj_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alive     <= 1'b0;
            r_inj_wp    <= '0;
            r_inj_rp    <= '0;
            r_inj_count <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_inj_push) begin
                r_inj_wp <= r_inj_wp + 1'b1;
            end
            if (w_inj_pop) begin
                r_inj_rp <= r_inj_rp + 1'b1;
            end
            case ({w_inj_push, w_inj_pop})
                2'b10:   r_inj_count <= r_inj_count + 1'b1;
                2'b01:   r_inj_count <= r_inj_count - 1'b1;
                default: r_inj_count <= r_inj_count;
            endcase
        end
    end

    // ---------------- inject FSM ----------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [LAT_W-1:0] r_lat;
    logic [LAT_W-1:0] w_lat_nxt;
    logic [FW-1:0]    r_din_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lat      <= '0;
            r_din_hold <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lat   <= w_lat_nxt;
            if (r_state == S_PRESENT) begin
                r_din_hold <= w_inj_head;
            end
        end
    end

    // The grant is only meaningful on the single cycle GNT_LAT after presentation.
    always_comb begin
        w_state_nxt = r_state;
        w_lat_nxt   = r_lat;
        w_inj_pop   = 1'b0;
        w_retry     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_inj_count != '0) begin
                    w_state_nxt = S_PRESENT;
                end
            end
            S_PRESENT: begin
                w_lat_nxt   = LAT_INIT;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_lat != '0) begin
                    w_lat_nxt = r_lat - 1'b1;
                end else if (local_inject_gnt) begin
                    w_inj_pop   = 1'b1;
                    w_state_nxt = ((r_inj_count > (IAW+1)'(1)) || w_inj_push) ? S_PRESENT : S_IDLE;
                end else begin
                    w_retry     = 1'b1;
                    w_state_nxt = S_PRESENT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        din_l = r_din_hold;
        if (r_state == S_PRESENT) begin
            din_l     = w_inj_head;
            din_l[VB] = 1'b1;
        end
    end

    assign o_dbg_state     = r_state;
    assign o_dbg_inj_count = r_inj_count;

    // ---------------- ejection FIFO ----------------
    logic [FW-1:0]    r_ej_mem [EJ_DEPTH];
    logic [EAW-1:0]   r_ej_wp;
    logic [EAW-1:0]   r_ej_rp;
    logic [EAW:0]     r_ej_count;
    logic             r_ej_overflow;
    logic [EAW:0]     w_ej_free;
    logic             w_l1_v;
    logic             w_l2_v;
    logic             w_wr1;
    logic             w_wr2;
    logic [1:0]       w_nwr;
    logic [EAW-1:0]   w_wr2_idx;
    logic             w_ej_pop;
    logic             w_drop;

    // Room is judged on the start-of-cycle count; a same-cycle pop never makes space.
    assign w_ej_free = EJ_FULL - r_ej_count;
    assign w_l1_v    = dout_l_1[VB];
    assign w_l2_v    = dout_l_2[VB];
    assign w_wr1     = w_l1_v && (w_ej_free != '0);
    assign w_wr2     = w_l2_v && (w_l1_v ? (w_ej_free >= (EAW+1)'(2)) : (w_ej_free != '0));
    assign w_nwr     = {1'b0, w_wr1} + {1'b0, w_wr2};
    assign w_wr2_idx = w_wr1 ? (r_ej_wp + 1'b1) : r_ej_wp;
    assign w_drop    = (w_l1_v && !w_wr1) || (w_l2_v && !w_wr2);
    assign ej_valid  = (r_ej_count != '0);
    assign w_ej_pop  = ej_valid && ej_ready;
    assign ej_flit   = ej_valid ? r_ej_mem[r_ej_rp] : '0;

    always_ff @(posedge clk) begin
        if (w_wr1) begin
            r_ej_mem[r_ej_wp] <= dout_l_1;
        end
        if (w_wr2) begin
            r_ej_mem[w_wr2_idx] <= dout_l_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ej_wp       <= '0;
            r_ej_rp       <= '0;
            r_ej_count    <= '0;
            r_ej_overflow <= 1'b0;
        end else begin
            r_ej_wp    <= r_ej_wp + EAW'(w_nwr);
            r_ej_count <= r_ej_count + (EAW+1)'(w_nwr) - (EAW+1)'(w_ej_pop);
            if (w_ej_pop) begin
                r_ej_rp <= r_ej_rp + 1'b1;
            end
            if (w_drop) begin
                r_ej_overflow <= 1'b1;
            end
        end
    end

    assign ej_overflow    = r_ej_overflow;
    assign o_dbg_ej_count = r_ej_count;

    // ---------------- statistics ----------------
`ifdef NI_STATS_EN
    logic [CNT_W-1:0] r_stat_inj;
    logic [CNT_W-1:0] r_stat_ej;
    logic [CNT_W-1:0] r_stat_retry;
    logic [CNT_W:0]   w_ej_sum;

    assign w_ej_sum = {1'b0, r_stat_ej} + (CNT_W+1)'(w_nwr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_inj   <= '0;
            r_stat_ej    <= '0;
            r_stat_retry <= '0;
        end else begin
            if (w_inj_pop && (r_stat_inj != '1)) begin
                r_stat_inj <= r_stat_inj + 1'b1;
            end
            if (w_retry && (r_stat_retry != '1)) begin
                r_stat_retry <= r_stat_retry + 1'b1;
            end
            r_stat_ej <= w_ej_sum[CNT_W] ? '1 : w_ej_sum[CNT_W-1:0];
        end
    end

    assign inj_cnt   = r_stat_inj;
    assign ej_cnt    = r_stat_ej;
    assign retry_cnt = r_stat_retry;
`else
    assign inj_cnt   = '0;
    assign ej_cnt    = '0;
    assign retry_cnt = '0;
`endif

endmodule

// File: tb/tb_ni_minbd.sv
// Directed bench for ni_minbd: inject grant/retry sequencing, ejection capture/drop, reset mid-flight.
`ifndef WIDTH_FLIT_EXT
`define WIDTH_FLIT_EXT 40
`endif

module tb_ni_minbd;
  localparam int FW = `WIDTH_FLIT_EXT;
`ifdef NI_STATS_EN
  localparam logic STATS = 1'b1;
`else
  localparam logic STATS = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          inj_valid;
  logic          inj_ready;
  logic [FW-1:0] inj_flit;
  logic [FW-1:0] din_l;
  logic          local_inject_gnt;
  logic [FW-1:0] dout_l_1;
  logic [FW-1:0] dout_l_2;
  logic          ej_valid;
  logic          ej_ready;
  logic [FW-1:0] ej_flit;
  logic          ej_overflow;
  logic [15:0]   inj_cnt;
  logic [15:0]   ej_cnt;
  logic [15:0]   retry_cnt;
  logic [1:0]    dbg_state;
  logic [2:0]    dbg_inj_count;
  logic [3:0]    dbg_ej_count;

  ni_minbd dut (
    .clk              (clk),
    .rst              (rst),
    .inj_valid        (inj_valid),
    .inj_ready        (inj_ready),
    .inj_flit         (inj_flit),
    .din_l            (din_l),
    .local_inject_gnt (local_inject_gnt),
    .dout_l_1         (dout_l_1),
    .dout_l_2         (dout_l_2),
    .ej_valid         (ej_valid),
    .ej_ready         (ej_ready),
    .ej_flit          (ej_flit),
    .ej_overflow      (ej_overflow),
    .inj_cnt          (inj_cnt),
    .ej_cnt           (ej_cnt),
    .retry_cnt        (retry_cnt),
    .o_dbg_state      (dbg_state),
    .o_dbg_inj_count  (dbg_inj_count),
    .o_dbg_ej_count   (dbg_ej_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [FW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // flit layout: [39] vld, [38] golden, [37:36] dst_x, [35:34] dst_y, [33:0] payload
  function automatic logic [FW-1:0] mk(input logic v, input logic g, input logic [1:0] dx,
                                       input logic [1:0] dy, input logic [33:0] pl);
    return {v, g, dx, dy, pl};
  endfunction

  function automatic logic [FW-1:0] pres(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    r = f;
    r[39] = 1'b1;
    r[38] = 1'b0;
    return r;
  endfunction

  function automatic logic [FW-1:0] held(input logic [FW-1:0] f);
    logic [FW-1:0] r;
    r = f;
    r[39] = 1'b0;
    r[38] = 1'b0;
    return r;
  endfunction

  function automatic logic [FW-1:0] ej_mk(input int k);
    logic [1:0] kk;
    kk = k[1:0];
    return mk(1'b1, k[2], kk, ~kk, 34'h100 + 34'(k));
  endfunction

  // driver: called in a PRESENT cycle; grant forced high on the ignored cycle, g on the sampled one
  task automatic serve(input logic [FW-1:0] f, input logic g, input string tag);
    check({tag, "_present"}, din_l, pres(f));
    check({tag, "_state_p"}, dbg_state, 2'd1);
    tick();
    local_inject_gnt = 1'b1;
    check({tag, "_hold"}, din_l, held(f));
    tick();
    local_inject_gnt = g;
    check({tag, "_state_w"}, dbg_state, 2'd2);
    tick();
    local_inject_gnt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic drain(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, ej_valid, 1'b1);
      check({tag, "_flit"}, ej_flit, exp_q.size() > 0 ? exp_q.pop_front() : '0);
      ej_ready = 1'b1;
      tick();
      ej_ready = 1'b0;
    end
    check({tag, "_empty"}, ej_valid, 1'b0);
  endtask

  initial begin
    logic [FW-1:0] f1, f2, r0, r1;
    logic [FW-1:0] g_q[5];
    int pushed, seen, first_low, last_cyc;

    rst = 1'b1;
    inj_valid = 1'b0;
    inj_flit = '0;
    local_inject_gnt = 1'b0;
    dout_l_1 = '0;
    dout_l_2 = '0;
    ej_ready = 1'b0;
    tick();
    tick();
    check("rst_inj_ready", inj_ready, 1'b0);
    check("rst_din_l", din_l, '0);
    check("rst_ej_valid", ej_valid, 1'b0);
    check("rst_ej_flit", ej_flit, '0);
    check("rst_overflow", ej_overflow, 1'b0);
    check("rst_state", dbg_state, 2'd0);
    check("rst_inj_cnt", inj_cnt, '0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", inj_ready, 1'b1);

    // 1: single flit, granted on first sample
    f1 = mk(1'b0, 1'b0, 2'd2, 2'd1, 34'h1234);
    inj_valid = 1'b1;
    inj_flit = f1;
    tick();
    inj_valid = 1'b0;
    check("t1_idle_pre", dbg_state, 2'd0);
    check("t1_no_vld_pre", din_l[39], 1'b0);
    tick();
    serve(f1, 1'b1, "t1");
    check("t1_state_idle", dbg_state, 2'd0);
    check("t1_fifo_empty", dbg_inj_count, 3'd0);
    check("t1_vld_low", din_l[39], 1'b0);
    check("t1_inj_cnt", inj_cnt, STATS ? 16'd1 : 16'd0);
    tick();
    check("t1_no_repeat", din_l[39], 1'b0);

    // 2: two refused grants then accepted; core vld/golden bits ignored
    f2 = mk(1'b1, 1'b1, 2'd1, 2'd3, 34'h2_5A5A);
    inj_valid = 1'b1;
    inj_flit = f2;
    tick();
    inj_valid = 1'b0;
    tick();
    serve(f2, 1'b0, "t2a");
    serve(f2, 1'b0, "t2b");
    serve(f2, 1'b1, "t2c");
    check("t2_state_idle", dbg_state, 2'd0);
    check("t2_fifo_empty", dbg_inj_count, 3'd0);
    check("t2_retry_cnt", retry_cnt, STATS ? 16'd2 : 16'd0);
    check("t2_inj_cnt", inj_cnt, STATS ? 16'd2 : 16'd0);

    // 3: five back-to-back pushes into a 4-deep queue under constant grant
    exp_q.delete();
    for (int i = 0; i < 5; i++) g_q[i] = mk(i[0], i[1], 2'(i), 2'(3 - i), 34'h3000 + 34'(i));
    pushed = 0;
    seen = 0;
    first_low = -1;
    last_cyc = 0;
    local_inject_gnt = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (din_l[39]) begin
        seen++;
        check("t3_order", din_l, exp_q.size() > 0 ? exp_q.pop_front() : '0);
        if (seen > 1) check("t3_spacing", c - last_cyc, 3);
        last_cyc = c;
      end
      if (!inj_ready && first_low < 0) first_low = pushed;
      if (pushed < 5 && inj_ready) begin
        inj_valid = 1'b1;
        inj_flit = g_q[pushed];
        exp_q.push_back(pres(g_q[pushed]));
        pushed++;
      end else begin
        inj_valid = 1'b0;
      end
      tick();
    end
    local_inject_gnt = 1'b0;
    inj_valid = 1'b0;
    check("t3_ready_low_after4", first_low, 4);
    check("t3_seen", seen, 5);
    check("t3_state_idle", dbg_state, 2'd0);
    check("t3_fifo_empty", dbg_inj_count, 3'd0);
    check("t3_inj_cnt", inj_cnt, STATS ? 16'd7 : 16'd0);

    // 6: reset while waiting for a grant, grant arrives right after
    r0 = mk(1'b0, 1'b0, 2'd3, 2'd3, 34'h6000);
    r1 = mk(1'b0, 1'b0, 2'd0, 2'd1, 34'h6001);
    inj_valid = 1'b1;
    inj_flit = r0;
    tick();
    inj_flit = r1;
    tick();
    inj_valid = 1'b0;
    dout_l_1 = ej_mk(9);
    check("t6_present", din_l, pres(r0));
    tick();
    dout_l_1 = '0;
    check("t6_waiting", dbg_state, 2'd2);
    check("t6_ej_before", ej_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    local_inject_gnt = 1'b1;
    check("t6_din_zero", din_l, '0);
    check("t6_state_idle", dbg_state, 2'd0);
    check("t6_fifo_empty", dbg_inj_count, 3'd0);
    check("t6_ej_empty", ej_valid, 1'b0);
    check("t6_ready_low", inj_ready, 1'b0);
    tick();
    local_inject_gnt = 1'b0;
    check("t6_post_state", dbg_state, 2'd0);
    check("t6_post_count", dbg_inj_count, 3'd0);
    check("t6_inj_cnt", inj_cnt, 16'd0);
    check("t6_retry_cnt", retry_cnt, 16'd0);
    check("t6_ej_cnt", ej_cnt, 16'd0);
    tick();
    tick();
    check("t6_no_present", din_l[39], 1'b0);

    // 4: both ejectors every cycle, no pops: 8 stored, 5th cycle drops both
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      dout_l_1 = ej_mk(2 * k);
      dout_l_2 = ej_mk(2 * k + 1);
      if (k < 4) begin
        exp_q.push_back(ej_mk(2 * k));
        exp_q.push_back(ej_mk(2 * k + 1));
      end
      if (k == 0) check("t4_not_visible_yet", ej_valid, 1'b0);
      if (k == 4) check("t4_no_ovf_before", ej_overflow, 1'b0);
      tick();
    end
    dout_l_1 = '0;
    dout_l_2 = '0;
    check("t4_overflow", ej_overflow, 1'b1);
    check("t4_count", dbg_ej_count, 4'd8);
    check("t4_ej_cnt", ej_cnt, STATS ? 16'd8 : 16'd0);
    drain(8, "t4_pop");
    check("t4_ovf_sticky", ej_overflow, 1'b1);

    // 5: count 7, both valid with a pop -> l_1 kept, l_2 dropped
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      dout_l_1 = ej_mk(20 + 2 * k);
      dout_l_2 = ej_mk(21 + 2 * k);
      exp_q.push_back(ej_mk(20 + 2 * k));
      exp_q.push_back(ej_mk(21 + 2 * k));
      tick();
    end
    dout_l_1 = mk(1'b0, 1'b0, 2'd1, 2'd1, 34'h7777);
    dout_l_2 = ej_mk(26);
    exp_q.push_back(ej_mk(26));
    tick();
    check("t5_count7", dbg_ej_count, 4'd7);
    check("t5_no_ovf", ej_overflow, 1'b0);
    dout_l_1 = ej_mk(27);
    dout_l_2 = ej_mk(28);
    ej_ready = 1'b1;
    check("t5_head", ej_flit, exp_q.pop_front());
    exp_q.push_back(ej_mk(27));
    tick();
    ej_ready = 1'b0;
    dout_l_1 = '0;
    dout_l_2 = '0;
    check("t5_overflow", ej_overflow, 1'b1);
    check("t5_count_stays", dbg_ej_count, 4'd7);
    check("t5_ej_cnt", ej_cnt, STATS ? 16'd8 : 16'd0);
    drain(7, "t5_pop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
